// File: rtl/axis_pkt_gen_pkg.sv
// Shared types, TUSER field layout and the byte-pattern rule for the AXIS TX packet generator.
package axis_pkt_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // TUSER first-beat field offsets and widths
    localparam int LEN_LO      = 0;
    localparam int SRC_LO      = 16;
    localparam int DST_LO      = 24;
    localparam int SEQ_LO      = 32;
    localparam int LEN_FIELD_W = 16;
    localparam int PORT_W      = 8;
    localparam int SEQ_W       = 32;

    // Byte j of a beat is the beat's base value (packet index + byte offset, mod 256) plus j.
    function automatic logic [7:0] pattern_byte(input logic [7:0] beat_base, input logic [7:0] lane);
        return beat_base + lane;
    endfunction

endpackage

// File: rtl/axis_keep_gen.sv
// Purpose: packet length -> beats per packet and last-beat byte-enable mask.
// Latency: purely combinational.
// Backpressure: none, no handshake involved.
module axis_keep_gen #(
    parameter int BYTES     = 32,
    parameter int LEN_WIDTH = 16
) (
    input  logic [LEN_WIDTH-1:0] len,
    output logic [BYTES-1:0]     last_keep,
    output logic [LEN_WIDTH-1:0] beats
);

    localparam logic [LEN_WIDTH-1:0] BYTES_L = LEN_WIDTH'(BYTES);

    logic [LEN_WIDTH-1:0] rem;

    always_comb begin
        rem       = len % BYTES_L;
        beats     = (len / BYTES_L) + ((rem != '0) ? LEN_WIDTH'(1) : LEN_WIDTH'(0));
        last_keep = '0;
        // A remainder of zero means the last beat is completely full.
        for (int j = 0; j < BYTES; j++) begin
            last_keep[j] = (rem == '0) || (LEN_WIDTH'(j) < rem);
        end
    end

endmodule

// File: rtl/axis_tx_pkt_gen.sv
// Purpose: AXI4-Stream burst generator of fixed-length patterned frames with TUSER port tags; PKT_GEN_SEQNUM_EN adds a sequence number in tuser[63:32].
// Latency: start at cycle t presents the first beat at t+1; back-to-back packets when ipg_cycles==0.
// Backpressure: beats advance only on tvalid&&tready; all beat fields hold steady while stalled.
module axis_tx_pkt_gen
    import axis_pkt_gen_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int LEN_WIDTH            = 16,
    parameter int GAP_WIDTH            = 8
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              start,
    input  logic [LEN_WIDTH-1:0]              num_pkts,
    input  logic [LEN_WIDTH-1:0]              pkt_len,
    input  logic [GAP_WIDTH-1:0]              ipg_cycles,
    input  logic [7:0]                        src_port,
    input  logic [7:0]                        dst_port,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic                              busy,
    output logic                              done,
    output logic [LEN_WIDTH-1:0]              pkts_sent
);

    localparam int         BYTES     = C_M_AXIS_DATA_WIDTH / 8;
    localparam logic [7:0] BEAT_STEP = 8'(BYTES % 256);

    state_t               state, state_nxt;
    logic [LEN_WIDTH-1:0] cfg_num, cfg_len, beat_cnt, beats, pkt_next;
    logic [GAP_WIDTH-1:0] cfg_ipg, gap_cnt;
    logic [7:0]           cfg_src, cfg_dst, beat_base;
    logic [BYTES-1:0]     last_keep, keep_w;
    logic                 sending, hs, last_beat, last_pkt;

    axis_keep_gen #(
        .BYTES     (BYTES),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_keep_gen (
        .len       (cfg_len),
        .last_keep (last_keep),
        .beats     (beats)
    );

    assign sending   = (state == ST_SEND);
    assign hs        = sending && m_axis_tready;
    assign last_beat = (beat_cnt == beats - LEN_WIDTH'(1));
    assign pkt_next  = pkts_sent + LEN_WIDTH'(1);
    assign last_pkt  = (pkt_next == cfg_num);
    assign keep_w    = last_beat ? last_keep : '1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (num_pkts == '0) ? ST_DONE : ST_SEND;
                end
            end
            ST_SEND: begin
                if (hs && last_beat) begin
                    if (last_pkt) begin
                        state_nxt = ST_DONE;
                    end else if (cfg_ipg != '0) begin
                        state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt <= GAP_WIDTH'(1)) begin
                    state_nxt = ST_SEND;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // beat_base tracks (packet index + byte offset of the current beat) mod 256.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cfg_num   <= '0;
            cfg_len   <= '0;
            cfg_ipg   <= '0;
            cfg_src   <= '0;
            cfg_dst   <= '0;
            pkts_sent <= '0;
            beat_cnt  <= '0;
            beat_base <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cfg_num   <= num_pkts;
                        cfg_len   <= (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
                        cfg_ipg   <= ipg_cycles;
                        cfg_src   <= src_port;
                        cfg_dst   <= dst_port;
                        pkts_sent <= '0;
                        beat_cnt  <= '0;
                        beat_base <= '0;
                    end
                end
                ST_SEND: begin
                    if (hs) begin
                        if (last_beat) begin
                            pkts_sent <= pkt_next;
                            beat_cnt  <= '0;
                            beat_base <= 8'(pkt_next);
                            gap_cnt   <= cfg_ipg;
                        end else begin
                            beat_cnt  <= beat_cnt + LEN_WIDTH'(1);
                            beat_base <= beat_base + BEAT_STEP;
                        end
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from registered state, so reset clears them immediately.
    always_comb begin
        busy          = (state != ST_IDLE);
        done          = (state == ST_DONE);
        m_axis_tvalid = sending;
        m_axis_tlast  = sending && last_beat;
        m_axis_tkeep  = '0;
        m_axis_tdata  = '0;
        m_axis_tuser  = '0;
        if (sending) begin
            m_axis_tkeep = keep_w;
            for (int j = 0; j < BYTES; j++) begin
                if (keep_w[j]) begin
                    m_axis_tdata[8*j +: 8] = pattern_byte(beat_base, 8'(j));
                end
            end
            if (beat_cnt == '0) begin
                m_axis_tuser[LEN_LO +: LEN_FIELD_W] = LEN_FIELD_W'(cfg_len);
                m_axis_tuser[SRC_LO +: PORT_W]      = cfg_src;
                m_axis_tuser[DST_LO +: PORT_W]      = cfg_dst;
`ifdef PKT_GEN_SEQNUM_EN
                m_axis_tuser[SEQ_LO +: SEQ_W]       = SEQ_W'(pkts_sent);
`endif
            end
        end
    end

endmodule

// File: tb/tb_axis_tx_pkt_gen.sv
// Randomized scoreboard bench for axis_tx_pkt_gen: a frame-level model fills expected-beat and gap queues, a negedge monitor checks them.
module tb_axis_tx_pkt_gen;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int W  = DW / 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [W-1:0]  k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic          CLK, RESET, start;
    logic [15:0]   num_pkts, pkt_len, pkts_sent;
    logic [7:0]    ipg_cycles, src_port, dst_port;
    logic [DW-1:0] m_axis_tdata;
    logic [W-1:0]  m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast, busy, done;

    axis_tx_pkt_gen dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .start         (start),
        .num_pkts      (num_pkts),
        .pkt_len       (pkt_len),
        .ipg_cycles    (ipg_cycles),
        .src_port      (src_port),
        .dst_port      (dst_port),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done),
        .pkts_sent     (pkts_sent)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int    total = 0;
    int    bad   = 0;
    int    rdy_mode = 0;
    beat_t exp_q[$];
    int    gap_q[$];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: byte k of packet n is (n+k) mod 256 for k < len, split into W-byte beats.
    task automatic model_burst(input int np, input int len, input int ipg, input logic [7:0] src, input logic [7:0] dst);
        int L, nb;
        beat_t e;
        L  = (len == 0) ? 1 : len;
        nb = (L + W - 1) / W;
        for (int n = 0; n < np; n++) begin
            for (int b = 0; b < nb; b++) begin
                e = '0;
                for (int j = 0; j < W; j++) begin
                    if (b * W + j < L) begin
                        e.d[8*j +: 8] = 8'((n + b * W + j) % 256);
                        e.k[j] = 1'b1;
                    end
                end
                e.l = (b == nb - 1);
                if (b == 0) begin
                    e.u[15:0]  = 16'(L);
                    e.u[23:16] = src;
                    e.u[31:24] = dst;
`ifdef PKT_GEN_SEQNUM_EN
                    e.u[63:32] = 32'(n % 65536);
`endif
                end
                exp_q.push_back(e);
            end
            if (n < np - 1) gap_q.push_back(ipg);
        end
    endtask

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: beat contents, stall stability, inter-packet gap, done latency.
    logic  in_gap = 1'b0, have_hold = 1'b0, hs_seen = 1'b0;
    int    gap_seen = 0, since_hs = 0;
    beat_t held, cur;

    always @(negedge CLK) begin
        cur = '{d: m_axis_tdata, k: m_axis_tkeep, u: m_axis_tuser, l: m_axis_tlast};
        if (RESET) begin
            in_gap = 1'b0; have_hold = 1'b0; hs_seen = 1'b0;
        end else begin
            if (have_hold) chk("stall_hold", {m_axis_tvalid, cur}, {1'b1, held});
            have_hold = m_axis_tvalid && !m_axis_tready;
            held = cur;
            if (hs_seen) since_hs++;
            if (done) begin
                if (hs_seen) chk("done_latency", since_hs, 1);
                hs_seen = 1'b0;
                in_gap  = 1'b0;
            end
            if (in_gap) begin
                if (!m_axis_tvalid) gap_seen++;
                else begin
                    if (gap_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL gap_unexpected: got packet start, expected none");
                    end else chk("ipg_gap", gap_seen, gap_q.pop_front());
                    in_gap = 1'b0;
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL beat_unexpected: got %0h expected no beat", cur);
                end else chk("beat", cur, exp_q.pop_front());
                if (m_axis_tlast) begin
                    in_gap = 1'b1; gap_seen = 0; hs_seen = 1'b1; since_hs = 0;
                end
            end
        end
    end

    task automatic burst(input int np, input int len, input int ipg, input int mode);
        logic [7:0] src, dst;
        int cyc;
        src = 8'(1 << $urandom_range(0, 7));
        dst = 8'(1 << $urandom_range(0, 7));
        model_burst(np, len, ipg, src, dst);
        rdy_mode = mode;
        @(posedge CLK); #1;
        start = 1'b1; num_pkts = 16'(np); pkt_len = 16'(len); ipg_cycles = 8'(ipg);
        src_port = src; dst_port = dst;
        @(posedge CLK); #1;
        start = 1'b0;
        if (np == 0) chk("start_latency_empty", {m_axis_tvalid, done}, 2'b01);
        else         chk("start_latency", {m_axis_tvalid, done, busy}, 3'b101);
        // Config churn and a stray start while busy must be ignored.
        num_pkts = 16'($urandom); pkt_len = 16'($urandom); ipg_cycles = 8'($urandom);
        src_port = 8'($urandom); dst_port = 8'($urandom); start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 5000) begin
            @(posedge CLK); #1;
            cyc++;
        end
        if (cyc >= 5000) begin
            total++; bad++;
            $display("FAIL burst_timeout: got busy after %0d cycles, expected idle", cyc);
        end
        chk("pkts_sent", pkts_sent, 16'(np));
        chk("idle_after", {busy, done, m_axis_tvalid}, 3'b000);
        chk("scoreboard_drain", exp_q.size() + gap_q.size(), 0);
        exp_q.delete(); gap_q.delete();
    endtask

    initial begin
        int cyc;
        RESET = 1'b1; start = 1'b0; num_pkts = '0; pkt_len = '0; ipg_cycles = '0;
        src_port = '0; dst_port = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs", {m_axis_tvalid, m_axis_tlast, busy, done, pkts_sent, m_axis_tkeep, m_axis_tdata, m_axis_tuser}, '0);
        RESET = 1'b0;

        burst(1, 64, 0, 0);
        burst(3, 65, 4, 0);
        burst(2, 60, 0, 1);
        burst(0, 10, 0, 0);
        burst(1, 0, 0, 0);
        burst(3, 48, 2, 2);
        for (int i = 0; i < 8; i++) begin
            burst($urandom_range(1, 4), $urandom_range(0, 150), $urandom_range(0, 5), $urandom_range(0, 2));
        end

        // Reset in the middle of packet 2 of 5.
        model_burst(5, 100, 2, 8'h01, 8'h02);
        rdy_mode = 0;
        @(posedge CLK); #1;
        start = 1'b1; num_pkts = 16'd5; pkt_len = 16'd100; ipg_cycles = 8'd2;
        src_port = 8'h01; dst_port = 8'h02;
        @(posedge CLK); #1;
        start = 1'b0;
        cyc = 0;
        while (!(pkts_sent == 16'd2 && m_axis_tvalid) && cyc < 2000) begin
            @(posedge CLK); #1;
            cyc++;
        end
        chk("reach_pkt2", {pkts_sent, m_axis_tvalid}, {16'd2, 1'b1});
        #2 RESET = 1'b1;
        #1;
        chk("reset_mid", {m_axis_tvalid, m_axis_tlast, busy, done, pkts_sent, m_axis_tkeep, m_axis_tdata, m_axis_tuser}, '0);
        exp_q.delete(); gap_q.delete();
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        burst(2, 40, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected bench completion");
        $fatal(1, "watchdog");
    end

endmodule
